// File: rtl/mini_cpu_pkg.sv
// Shared CPU-wide constants and types used by the fetch stage.
`timescale 1ns/1ps
package mini_cpu_pkg;

    localparam int              XLEN             = 32;
    localparam int              INSTR_W          = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; used as the fetch PC queue and the instruction buffer.
`timescale 1ns/1ps
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot, so a full FIFO may still accept
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC generation, imem req/gnt/rvalid handshake, instruction buffer, redirect.
// Optional build macro IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_bubble_cnt outputs.
`timescale 1ns/1ps
module ifu_fetch
    import mini_cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               stall,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_bubble_cnt
`endif
);

    localparam int             CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  pc_req;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   in_flight;
    logic [XLEN-1:0]  pcq_head;
    logic             pcq_full;
    logic             pcq_empty;
    logic             buf_full;
    logic             buf_empty;
    fetch_pkt_t       buf_wdata;
    fetch_pkt_t       buf_head;
    logic             issue;
    logic             rsp;
    logic             rsp_keep;
    logic             deliver;

    // outstanding requests are exactly the PC-queue occupancy
    assign in_flight = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req  = reset_n & ~redirect & ~pcq_full & ~buf_full & (in_flight < CREDIT_MAX);
    assign imem_addr = pc_req;
    assign issue     = imem_req & imem_gnt;
    assign rsp       = imem_rvalid & ~pcq_empty;
    assign rsp_keep  = rsp & (discard == '0);
    assign deliver   = ~buf_empty & ~stall;

    assign buf_wdata.pc    = pcq_head;
    assign buf_wdata.instr = imem_rdata;

    assign out_valid = ~buf_empty;
    assign out_instr = buf_empty ? '0 : buf_head.instr;
    assign out_pc    = buf_empty ? '0 : buf_head.pc;

    ifu_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pc_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (issue),
        .pop     (rsp),
        .flush   (1'b0),
        .wdata   (pc_req),
        .rdata   (pcq_head),
        .full    (pcq_full),
        .empty   (pcq_empty),
        .count   (outstanding)
    );

    ifu_fifo #(.WIDTH($bits(fetch_pkt_t)), .DEPTH(FIFO_DEPTH)) u_instr_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rsp_keep),
        .pop     (deliver),
        .flush   (redirect),
        .wdata   (buf_wdata),
        .rdata   (buf_head),
        .full    (buf_full),
        .empty   (buf_empty),
        .count   (buf_count)
    );

    // in-flight responses at redirect time are older-path words and must be dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_req  <= RESET_PC;
            discard <= '0;
        end else if (redirect) begin
            pc_req  <= word_align(redirect_pc);
            discard <= outstanding - CNT_W'(rsp);
        end else begin
            if (issue) pc_req <= pc_req + PC_STEP;
            if (rsp && discard != '0) discard <= discard - CNT_W'(1);
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (deliver && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (buf_empty && !redirect && perf_bubble_cnt != '1)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`else
    // performance counters are not built in this configuration
`endif

    rvalid_has_owner: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rvalid |-> !pcq_empty);

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: random imem timing against a queue-based reference model.
`timescale 1ns/1ps
module tb_ifu_fetch;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;
`endif

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    longint last_due = 0;
    int     lat_max  = 1;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pcq[$];
    logic [63:0] m_buf[$];
    int          m_discard;

    // memory model: pending addresses in request order with earliest response cycle
    logic [31:0] mem_addr_q[$];
    longint      mem_due_q[$];

    ifu_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic model_clear();
        m_pc      = RST_PC;
        m_pcq.delete();
        m_buf.delete();
        m_discard = 0;
        mem_addr_q.delete();
        mem_due_q.delete();
        last_due  = 0;
`ifdef IFU_PERF_CNT_EN
        m_fetch   = '0;
        m_bubble  = '0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        stall       = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // one clock: drive memory side, compare against the model, advance model
    task automatic step(input int gnt_pct);
        bit          rv;
        bit          exp_req;
        bit          exp_ov;
        logic [63:0] head;
        logic [31:0] p;
        longint      due;
        imem_gnt = ($urandom_range(0, 99) < gnt_pct);
        rv = 1'b0;
        if (mem_addr_q.size() > 0) rv = (mem_due_q[0] <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(mem_addr_q[0]) : $urandom;
        #1;
        exp_req = !redirect && ((m_pcq.size() + m_buf.size()) < DEPTH);
        exp_ov  = (m_buf.size() > 0);
        head    = exp_ov ? m_buf[0] : 64'h0;
        n_checks++;
        if (imem_req !== exp_req) begin
            n_fail++;
            $display("FAIL imem_req cyc=%0d got=%b want=%b", cyc, imem_req, exp_req);
        end
        n_checks++;
        if (imem_addr !== m_pc) begin
            n_fail++;
            $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_addr, m_pc);
        end
        n_checks++;
        if (out_valid !== exp_ov) begin
            n_fail++;
            $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_ov);
        end
        n_checks++;
        if (out_pc !== head[63:32]) begin
            n_fail++;
            $display("FAIL out_pc cyc=%0d got=%h want=%h", cyc, out_pc, head[63:32]);
        end
        n_checks++;
        if (out_instr !== head[31:0]) begin
            n_fail++;
            $display("FAIL out_instr cyc=%0d got=%h want=%h", cyc, out_instr, head[31:0]);
        end
`ifdef IFU_PERF_CNT_EN
        n_checks++;
        if (perf_fetch_cnt !== m_fetch) begin
            n_fail++;
            $display("FAIL perf_fetch_cnt cyc=%0d got=%0d want=%0d", cyc, perf_fetch_cnt, m_fetch);
        end
        n_checks++;
        if (perf_bubble_cnt !== m_bubble) begin
            n_fail++;
            $display("FAIL perf_bubble_cnt cyc=%0d got=%0d want=%0d", cyc, perf_bubble_cnt, m_bubble);
        end
        if (exp_ov && !stall && m_fetch != 32'hFFFF_FFFF) m_fetch++;
        if (!exp_ov && !redirect && m_bubble != 32'hFFFF_FFFF) m_bubble++;
`endif
        if (rv) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (imem_req === 1'b1 && imem_gnt) begin
            due = cyc + longint'($urandom_range(1, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_addr_q.push_back(imem_addr);
            mem_due_q.push_back(due);
        end
        if (redirect) begin
            if (rv && m_pcq.size() > 0) void'(m_pcq.pop_front());
            m_discard = m_pcq.size();
            m_buf.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (exp_ov && !stall) void'(m_buf.pop_front());
            if (rv && m_pcq.size() > 0) begin
                p = m_pcq.pop_front();
                if (m_discard > 0) m_discard--;
                else m_buf.push_back({p, mem_word(p)});
            end
            if (exp_req && imem_gnt) begin
                m_pcq.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input int gnt_pct, input int stall_pct, input int redir_pct);
        for (int i = 0; i < n; i++) begin
            stall       = ($urandom_range(0, 99) < stall_pct);
            redirect    = ($urandom_range(0, 99) < redir_pct);
            redirect_pc = $urandom;
            step(gnt_pct);
        end
        redirect = 1'b0;
        stall    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got  [5];
        logic [31:0] want [5];
        string       nm   [5];
        model_clear();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        got  = '{32'(imem_req), imem_addr, 32'(out_valid), out_instr, out_pc};
        want = '{32'd0, RST_PC, 32'd0, 32'd0, 32'd0};
        nm   = '{"rst_imem_req", "rst_imem_addr", "rst_out_valid", "rst_out_instr", "rst_out_pc"};
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (got[i] !== want[i]) begin
                n_fail++;
                $display("FAIL %s got=%h want=%h", nm[i], got[i], want[i]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_stream();
        lat_max = 1;
        run(20, 100, 0, 0);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_valid got=%b want=1", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        do_reset();
        lat_max = 1;
        run(2, 100, 0, 0);
        stall = 1'b1;
        step(100);
        held = m_buf[0][63:32];
        for (int i = 0; i < 5; i++) begin
            step(100);
            n_checks++;
            if (out_pc !== held) begin
                n_fail++;
                $display("FAIL stall_hold got=%h want=%h", out_pc, held);
            end
        end
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_req got=%b want=0", imem_req);
        end
        stall = 1'b0;
        step(100);
        n_checks++;
        if (out_pc !== held + 32'd4) begin
            n_fail++;
            $display("FAIL stall_release got=%h want=%h", out_pc, held + 32'd4);
        end
        run(10, 100, 0, 0);
    endtask

    task automatic test_gnt_wait();
        int guard;
        do_reset();
        lat_max = 1;
        guard = 0;
        while (m_pc != 32'h10 && guard < 30) begin
            step(100);
            guard++;
        end
        n_checks++;
        if (m_pc != 32'h10) begin
            n_fail++;
            $display("FAIL gnt_reach got=%h want=%h", imem_addr, 32'h10);
        end
        for (int i = 0; i < 3; i++) begin
            step(0);
            n_checks++;
            if (imem_addr !== 32'h10) begin
                n_fail++;
                $display("FAIL gnt_hold got=%h want=%h", imem_addr, 32'h10);
            end
        end
        guard = 0;
        while (m_pc == 32'h10 && guard < 10) begin
            step(100);
            guard++;
        end
        n_checks++;
        if (imem_addr !== 32'h14) begin
            n_fail++;
            $display("FAIL gnt_next got=%h want=%h", imem_addr, 32'h14);
        end
        run(40, 40, 20, 0);
    endtask

    task automatic test_redirect();
        int guard;
        do_reset();
        lat_max = 4;
        guard = 0;
        while (m_pcq.size() < 2 && guard < 20) begin
            step(100);
            guard++;
        end
        n_checks++;
        if (m_pcq.size() != 2) begin
            n_fail++;
            $display("FAIL redir_setup got=%0d want=2", m_pcq.size());
        end
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step(100);
        redirect = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_out_valid got=%b want=0", out_valid);
        end
        n_checks++;
        if (imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_addr got=%h want=%h", imem_addr, 32'h100);
        end
        guard = 0;
        while (out_valid !== 1'b1 && guard < 40) begin
            step(100);
            guard++;
        end
        n_checks++;
        if (out_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_first_pc got=%h want=%h", out_pc, 32'h100);
        end
        run(20, 80, 10, 0);
    endtask

    task automatic test_redirect_rvalid_stall();
        int  guard;
        bit  hit;
        do_reset();
        lat_max = 3;
        stall   = 1'b1;
        guard   = 0;
        hit     = 1'b0;
        while (!hit && guard < 60) begin
            if (mem_addr_q.size() > 0 && m_buf.size() > 0)
                hit = (mem_due_q[0] <= cyc);
            if (!hit) begin
                step(100);
                guard++;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL redir_rv_setup got=0 want=1");
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step(100);
        redirect = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_rv_flush got=%b want=0", out_valid);
        end
        stall = 1'b0;
        run(20, 100, 0, 0);
    endtask

    task automatic test_wrap();
        bit seen;
        do_reset();
        lat_max     = 2;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF6;
        step(100);
        redirect = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(100);
            if (out_valid === 1'b1 && out_pc === 32'h0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_pc0 got=%b want=1", seen);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 6; c++) begin
            lat_max = $urandom_range(1, 4);
            run(400, $urandom_range(30, 100), 30, 3);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got  [5];
        logic [31:0] want [5];
        string       nm   [5];
        lat_max = 2;
        run(13, 100, 10, 0);
        #3;
        reset_n = 1'b0;
        #1;
        got  = '{32'(imem_req), imem_addr, 32'(out_valid), out_instr, out_pc};
        want = '{32'd0, RST_PC, 32'd0, 32'd0, 32'd0};
        nm   = '{"arst_imem_req", "arst_imem_addr", "arst_out_valid", "arst_out_instr", "arst_out_pc"};
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (got[i] !== want[i]) begin
                n_fail++;
                $display("FAIL %s got=%h want=%h", nm[i], got[i], want[i]);
            end
        end
`ifdef IFU_PERF_CNT_EN
        n_checks++;
        if (perf_fetch_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL arst_perf_fetch got=%0d want=0", perf_fetch_cnt);
        end
`endif
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        lat_max = 1;
        run(20, 100, 0, 0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_gnt_wait();
        test_redirect();
        test_redirect_rvalid_stall();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
